// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   NOP_INST    : canonical bubble instruction (addi x0,x0,0)
//   PC_STEP     : byte distance between consecutive fetch addresses
//   req_state_e : instruction-memory request FSM encoding
package rv_pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_PEND = 1'b1
    } req_state_e;

endpackage

// File: rtl/if_fetch_buffer.sv
// Two-entry {PC, instruction} FIFO between the imem response port and IF/ID.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   push, push_pc/inst    : write one entry (ignored when full unless popping)
//   pop                   : drop the head entry (ignored when empty)
//   flush                 : clear everything; wins over push and pop
//   head_pc, head_inst    : head entry contents (meaningless when empty)
//   count, full, empty    : occupancy
module if_fetch_buffer
    import rv_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty
);

    logic [31:0] pc_q   [2];
    logic [31:0] pc_d   [2];
    logic [31:0] inst_q [2];
    logic [31:0] inst_d [2];
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  count_q, count_d;
    logic        do_push, do_pop;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign count     = count_q;
    assign head_pc   = pc_q[rd_q];
    assign head_inst = inst_q[rd_q];

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        do_pop  = pop && !empty;
        // A full buffer may take a new entry only when the head leaves this cycle.
        do_push = push && (!full || do_pop);
        if (flush) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            count_d = 2'd0;
        end else begin
            if (do_push) begin
                pc_d[wr_q]   = push_pc;
                inst_d[wr_q] = push_inst;
                wr_d         = ~wr_q;
            end
            if (do_pop) begin
                rd_d = ~rd_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
            inst_q[0] <= NOP_INST;
            inst_q[1] <= NOP_INST;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC generation, in-order imem requests, 2-entry
// instruction buffer feeding the IF/ID register.
// Ports:
//   clk_IF, rst_IF        : clock, synchronous active-high reset
//   en_IF                 : IF/ID accepts the head entry this cycle (0 = stall)
//   redirect_IF/_PC_IF    : taken branch/jump; flush and refetch from target
//   imem_req/addr/gnt_IF  : request handshake; addr held stable until gnt
//   imem_rvalid/rdata_IF  : in-order responses, at least one cycle after gnt
//   PC_out/inst_out_IF    : head entry (0 / NOP_INST when empty)
//   valid_out_IF          : head entry valid
//   NOP_out_IF            : bubble into IF/ID (empty buffer or redirect)
//   dbg_*                 : request FSM state, in-flight and discard counters
// Handshake: a request transfers on a cycle with imem_req_IF & imem_gnt_IF;
// the address stays constant while imem_req_IF is high and gnt is low. IF/ID
// takes the head on a cycle with en_IF & valid_out_IF & ~redirect_IF.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv_pipe_pkg::NOP_INST
) (
    input  logic                   clk_IF,
    input  logic                   rst_IF,
    input  logic                   en_IF,
    input  logic                   redirect_IF,
    input  logic [31:0]            redirect_PC_IF,
    output logic                   imem_req_IF,
    output logic [31:0]            imem_addr_IF,
    input  logic                   imem_gnt_IF,
    input  logic                   imem_rvalid_IF,
    input  logic [31:0]            imem_rdata_IF,
    output logic [31:0]            PC_out_IF,
    output logic [31:0]            inst_out_IF,
    output logic                   valid_out_IF,
    output logic                   NOP_out_IF,
    output rv_pipe_pkg::req_state_e dbg_state_IF,
    output logic [1:0]             dbg_inflight_IF,
    output logic [2:0]             dbg_discard_IF
);
    import rv_pipe_pkg::*;

    req_state_e  state_q, state_d;
    logic [31:0] pc_fetch_q, pc_fetch_d;
    logic [1:0]  inflight_q, inflight_d;
    // Stale responses still owed by imem after redirects; back-to-back
    // redirects can stack more than two.
    logic [2:0]  discard_q, discard_d;
    // Issue-PC tags for requests granted but not yet answered.
    logic [31:0] tag_q [2];
    logic [31:0] tag_d [2];
    logic        tag_rd_q, tag_rd_d;
    logic        tag_wr_q, tag_wr_d;

    logic        gnt_acc, resp_drop, resp_take;
    logic        buf_push, buf_pop;
    logic [31:0] buf_head_pc, buf_head_inst;
    logic [1:0]  buf_count, buf_count_nxt;
    logic        buf_full, buf_empty;
    logic [2:0]  in_use_nxt;

    assign imem_req_IF     = (state_q == REQ_PEND);
    assign imem_addr_IF    = pc_fetch_q;
    assign valid_out_IF    = !buf_empty;
    assign PC_out_IF       = valid_out_IF ? buf_head_pc   : 32'h0;
    assign inst_out_IF     = valid_out_IF ? buf_head_inst : NOP_INST;
    assign NOP_out_IF      = redirect_IF | ~valid_out_IF;
    assign dbg_state_IF    = state_q;
    assign dbg_inflight_IF = inflight_q;
    assign dbg_discard_IF  = discard_q;

    assign gnt_acc   = imem_req_IF && imem_gnt_IF;
    assign resp_drop = imem_rvalid_IF && (discard_q != 3'd0);
    // A response with nothing outstanding belongs to a pre-reset request.
    assign resp_take = imem_rvalid_IF && (discard_q == 3'd0) && (inflight_q != 2'd0);
    assign buf_push  = resp_take && !redirect_IF && (!buf_full || buf_pop);
    assign buf_pop   = en_IF && valid_out_IF && !redirect_IF;

    always_comb begin
        pc_fetch_d = pc_fetch_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        tag_d      = tag_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        state_d    = state_q;

        if (redirect_IF) begin
            // Everything outstanding (plus a request granted right now) turns
            // stale; a response arriving this cycle is consumed as stale.
            pc_fetch_d = redirect_PC_IF & ~32'h3;
            inflight_d = 2'd0;
            discard_d  = discard_q - {2'b0, resp_drop} + {1'b0, inflight_q}
                         - {2'b0, resp_take} + {2'b0, gnt_acc};
            tag_rd_d   = 1'b0;
            tag_wr_d   = 1'b0;
            state_d    = REQ_IDLE;
        end else begin
            inflight_d = inflight_q + {1'b0, gnt_acc} - {1'b0, resp_take};
            discard_d  = discard_q - {2'b0, resp_drop};
            if (gnt_acc) begin
                pc_fetch_d      = pc_fetch_q + PC_STEP;
                tag_d[tag_wr_q] = pc_fetch_q;
                tag_wr_d        = ~tag_wr_q;
            end
            if (resp_take) begin
                tag_rd_d = ~tag_rd_q;
            end
        end

        buf_count_nxt = redirect_IF ? 2'd0
                      : buf_count + {1'b0, buf_push} - {1'b0, buf_pop};
        in_use_nxt    = {1'b0, buf_count_nxt} + {1'b0, inflight_d};

        if (!redirect_IF) begin
            case (state_q)
                REQ_IDLE: if (in_use_nxt < 3'd2) state_d = REQ_PEND;
                REQ_PEND: if (gnt_acc && in_use_nxt >= 3'd2) state_d = REQ_IDLE;
                default:  state_d = REQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_IF) begin
        if (rst_IF) begin
            state_q    <= REQ_IDLE;
            pc_fetch_q <= RESET_PC;
            inflight_q <= 2'd0;
            discard_q  <= 3'd0;
            tag_q[0]   <= '0;
            tag_q[1]   <= '0;
            tag_rd_q   <= 1'b0;
            tag_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_fetch_q <= pc_fetch_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            tag_q      <= tag_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    if_fetch_buffer u_buf (
        .clk       (clk_IF),
        .rst       (rst_IF),
        .push      (buf_push),
        .push_pc   (tag_q[tag_rd_q]),
        .push_inst (imem_rdata_IF),
        .pop       (buf_pop),
        .flush     (redirect_IF),
        .head_pc   (buf_head_pc),
        .head_inst (buf_head_inst),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule
